seg7_scan_decoder: RTL and testbench

//  Reverse path of our BCD->7-segment encoding: snoops a multiplexed display bus (one-hot digit

---
 rtl/seg7_scan_decoder.sv | 163 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// ============================================================================
// Module      : seg7_scan_decoder
// Description : Snoops a multiplexed 7-segment bus, qualifies each digit's
//               pattern by repeated identical samples and decodes it to BCD.
//               Optional macro SEG7_DP_DECODE_EN enables decimal-point decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_en,
    input  logic [NUM_DIGITS-1:0]     an_in,
    input  logic [7:0]                seg_in,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     dp_out,
    output logic [NUM_DIGITS-1:0]     digit_err,
    output logic                      frame_valid
);

    localparam int         c_KEY_W      = NUM_DIGITS + 8;
    localparam logic [0:0] c_ST_ACQUIRE = 1'b0;
    localparam logic [0:0] c_ST_LOCKED  = 1'b1;

`ifdef SEG7_DP_DECODE_EN
    localparam logic c_DP_EN = 1'b1;
`else
    localparam logic c_DP_EN = 1'b0;
`endif

    logic [0:0]              r_state_q, w_state_d;
    logic [3:0]              r_cnt_q,   w_cnt_d;
    logic [c_KEY_W-1:0]      r_prev_q,  w_prev_d;
    logic [4*NUM_DIGITS-1:0] r_bcd_q,   w_bcd_d;
    logic [NUM_DIGITS-1:0]   r_dp_q,    w_dp_d;
    logic [NUM_DIGITS-1:0]   r_err_q,   w_err_d;
    logic [NUM_DIGITS-1:0]   r_seen_q,  w_seen_d;
    logic                    r_fv_q,    w_fv_d;

    logic                    w_dp_bit;
    logic [c_KEY_W-1:0]      w_key;
    logic                    w_onehot;
    logic                    w_match;
    logic [3:0]              w_cnt_inc;
    logic                    w_commit;
    logic [3:0]              w_dec_val;
    logic                    w_dec_err;

    // With DP decode disabled the dp bit is masked out of the key, so toggling it never breaks qualification.
    assign w_dp_bit  = seg_in[7] & c_DP_EN;
    assign w_key     = {an_in, w_dp_bit, seg_in[6:0]};
    assign w_onehot  = ($countones(an_in) == 1);
    assign w_match   = (w_key == r_prev_q);
    assign w_cnt_inc = w_match ? (r_cnt_q + 4'd1) : 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_ST_ACQUIRE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_prev_d  = r_prev_q;
        w_commit  = 1'b0;
        if (sample_en) begin
            if (!w_onehot) begin
                w_state_d = c_ST_ACQUIRE;
                w_cnt_d   = 4'd0;
                w_prev_d  = '0;
            end else if (!((r_state_q == c_ST_LOCKED) && w_match)) begin
                w_prev_d = w_key;
                w_cnt_d  = w_cnt_inc;
                if (w_cnt_inc >= 4'(STABLE_CNT)) begin
                    w_commit  = 1'b1;
                    w_state_d = c_ST_LOCKED;
                end else begin
                    w_state_d = c_ST_ACQUIRE;
                end
            end
        end
    end

    always_comb begin
        w_dec_val = 4'hE;
        w_dec_err = 1'b0;
        case (seg_in[6:0])
            7'h3F:   w_dec_val = 4'h0;
            7'h06:   w_dec_val = 4'h1;
            7'h5B:   w_dec_val = 4'h2;
            7'h4F:   w_dec_val = 4'h3;
            7'h66:   w_dec_val = 4'h4;
            7'h6D:   w_dec_val = 4'h5;
            7'h7D:   w_dec_val = 4'h6;
            7'h07:   w_dec_val = 4'h7;
            7'h7F:   w_dec_val = 4'h8;
            7'h67:   w_dec_val = 4'h9;
            7'h00:   w_dec_val = 4'hF;
            default: begin
                w_dec_val = 4'hE;
                w_dec_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_bcd_d  = r_bcd_q;
        w_dp_d   = r_dp_q;
        w_err_d  = r_err_q;
        w_seen_d = r_seen_q;
        w_fv_d   = 1'b0;
        if (w_commit) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (an_in[d]) begin
                    w_bcd_d[4*d +: 4] = w_dec_val;
                    w_dp_d[d]         = w_dp_bit;
                    w_err_d[d]        = w_dec_err;
                end
            end
            // The commit that completes the frame pulses once and restarts tracking.
            w_seen_d = r_seen_q | an_in;
            if (&w_seen_d) begin
                w_fv_d   = 1'b1;
                w_seen_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q  <= 4'd0;
            r_prev_q <= '0;
            r_bcd_q  <= {NUM_DIGITS{4'hF}};
            r_dp_q   <= '0;
            r_err_q  <= '0;
            r_seen_q <= '0;
            r_fv_q   <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_prev_q <= w_prev_d;
            r_bcd_q  <= w_bcd_d;
            r_dp_q   <= w_dp_d;
            r_err_q  <= w_err_d;
            r_seen_q <= w_seen_d;
            r_fv_q   <= w_fv_d;
        end
    end

    assign bcd_out     = r_bcd_q;
    assign dp_out      = r_dp_q;
    assign digit_err   = r_err_q;
    assign frame_valid = r_fv_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
// ============================================================================
// Module      : tb_seg7_scan_decoder
// Description : Scoreboard bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CNT=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst;
    logic        sample_en;
    logic [3:0]  an_in;
    logic [7:0]  seg_in;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out;
    logic [3:0]  digit_err;
    logic        frame_valid;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        string       nm;
        logic [15:0] bcd;
        logic [3:0]  err;
        logic [3:0]  dp;
        logic        fv;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_bcd;
    logic [3:0]  exp_err;
    logic [3:0]  exp_dp;

    seg7_scan_decoder #(
        .NUM_DIGITS (4),
        .STABLE_CNT (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .an_in       (an_in),
        .seg_in      (seg_in),
        .bcd_out     (bcd_out),
        .dp_out      (dp_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each pushed expectation belongs to the rising edge that follows it.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks += 4;
            if (bcd_out !== e.bcd) begin
                errors++;
                $display("FAIL %s bcd_out got=%h exp=%h", e.nm, bcd_out, e.bcd);
            end
            if (digit_err !== e.err) begin
                errors++;
                $display("FAIL %s digit_err got=%b exp=%b", e.nm, digit_err, e.err);
            end
            if (dp_out !== e.dp) begin
                errors++;
                $display("FAIL %s dp_out got=%b exp=%b", e.nm, dp_out, e.dp);
            end
            if (frame_valid !== e.fv) begin
                errors++;
                $display("FAIL %s frame_valid got=%b exp=%b", e.nm, frame_valid, e.fv);
            end
        end
    end

    task automatic sample(input logic [3:0] an, input logic [7:0] seg, input logic en,
                          input logic cm, input logic [3:0] val, input logic er,
                          input logic dpv, input logic fv, input string nm);
        exp_t e;
        @(negedge clk);
        an_in     = an;
        seg_in    = seg;
        sample_en = en;
        if (cm) begin
            for (int d = 0; d < 4; d++) begin
                if (an[d]) begin
                    exp_bcd[4*d +: 4] = val;
                    exp_err[d]        = er;
                    exp_dp[d]         = dpv;
                end
            end
        end
        e.nm  = nm;
        e.bcd = exp_bcd;
        e.err = exp_err;
        e.dp  = exp_dp;
        e.fv  = fv;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        sample_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        exp_bcd = 16'hFFFF;
        exp_err = 4'h0;
        exp_dp  = 4'h0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 4;
        if (bcd_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset bcd_out got=%h exp=ffff", bcd_out);
        end
        if (dp_out !== 4'h0) begin
            errors++;
            $display("FAIL reset dp_out got=%b exp=0000", dp_out);
        end
        if (digit_err !== 4'h0) begin
            errors++;
            $display("FAIL reset digit_err got=%b exp=0000", digit_err);
        end
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset frame_valid got=%b exp=0", frame_valid);
        end
    endtask

    task automatic test_single_digit();
        sample(4'b0001, 8'h5B, 1, 0, 4'h0, 0, 0, 0, "single_s1");
        sample(4'b0001, 8'h5B, 1, 0, 4'h0, 0, 0, 0, "single_s2");
        sample(4'b0001, 8'h5B, 1, 1, 4'h2, 0, 0, 0, "single_commit");
        sample(4'b0001, 8'h5B, 1, 0, 4'h0, 0, 0, 0, "single_locked");
    endtask

    task automatic test_scan();
        logic [7:0] pats [4];
        logic [3:0] vals [4];
        pats = '{8'h3F, 8'h06, 8'h4F, 8'h66};
        vals = '{4'h0, 4'h1, 4'h3, 4'h4};
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < 4; d++) begin
                sample(4'(1 << d), pats[d], 1, 0, 4'h0, 0, 0, 0, "scan_acq");
                sample(4'(1 << d), pats[d], 1, 0, 4'h0, 0, 0, 0, "scan_acq");
                sample(4'(1 << d), pats[d], 1, 1, vals[d], 0, 0, (d == 3), "scan_commit");
            end
        end
        if (exp_bcd !== 16'h4310) begin
            errors++;
            $display("FAIL scan_table expected=%h required=4310", exp_bcd);
        end
        checks++;
    endtask

    task automatic test_requalify();
        sample(4'b0010, 8'h5B, 1, 0, 4'h0, 0, 0, 0, "requal_5b");
        sample(4'b0010, 8'h5B, 1, 0, 4'h0, 0, 0, 0, "requal_5b");
        sample(4'b0010, 8'h7F, 1, 0, 4'h0, 0, 0, 0, "requal_7f");
        sample(4'b0010, 8'h7F, 1, 0, 4'h0, 0, 0, 0, "requal_7f");
        sample(4'b0010, 8'h7F, 1, 1, 4'h8, 0, 0, 0, "requal_commit8");
        for (int i = 0; i < 6; i++)
            sample(4'b0010, (i % 2) ? 8'h06 : 8'h3F, 1, 0, 4'h0, 0, 0, 0, "toggle_nocommit");
    endtask

    task automatic test_illegal_and_blank();
        sample(4'b0100, 8'h49, 1, 0, 4'h0, 0, 0, 0, "illegal_acq");
        sample(4'b0100, 8'h49, 1, 0, 4'h0, 0, 0, 0, "illegal_acq");
        sample(4'b0100, 8'h49, 1, 1, 4'hE, 1, 0, 0, "illegal_commit");
        sample(4'b0100, 8'h00, 1, 0, 4'h0, 0, 0, 0, "blank_acq");
        sample(4'b0100, 8'h00, 1, 0, 4'h0, 0, 0, 0, "blank_acq");
        sample(4'b0100, 8'h00, 1, 1, 4'hF, 0, 0, 0, "blank_commit");
    endtask

    task automatic test_reject_gate_reset();
        for (int i = 0; i < 4; i++)
            sample(4'b0011, 8'h3F, 1, 0, 4'h0, 0, 0, 0, "multihot_reject");
        for (int i = 0; i < 3; i++)
            sample(4'b0000, 8'h3F, 1, 0, 4'h0, 0, 0, 0, "zero_an_reject");
        sample(4'b0001, 8'h6D, 1, 0, 4'h0, 0, 0, 0, "gated_s1");
        sample(4'b0001, 8'h6D, 0, 0, 4'h0, 0, 0, 0, "gated_idle");
        sample(4'b0011, 8'h00, 0, 0, 4'h0, 0, 0, 0, "gated_idle_junk");
        sample(4'b0001, 8'h6D, 1, 0, 4'h0, 0, 0, 0, "gated_s2");
        sample(4'b0001, 8'h6D, 0, 0, 4'h0, 0, 0, 0, "gated_idle");
        sample(4'b0001, 8'h6D, 1, 1, 4'h5, 0, 0, 0, "gated_commit");
        sample(4'b1000, 8'h7D, 1, 0, 4'h0, 0, 0, 0, "cnt_clear_s1");
        sample(4'b1000, 8'h7D, 1, 0, 4'h0, 0, 0, 0, "cnt_clear_s2");
        sample(4'b0011, 8'h7D, 1, 0, 4'h0, 0, 0, 0, "cnt_clear_reject");
        sample(4'b1000, 8'h7D, 1, 0, 4'h0, 0, 0, 0, "cnt_clear_r1");
        sample(4'b1000, 8'h7D, 1, 0, 4'h0, 0, 0, 0, "cnt_clear_r2");
        sample(4'b1000, 8'h7D, 1, 1, 4'h6, 0, 0, 1, "cnt_clear_commit_frame");
        sample(4'b0001, 8'h07, 1, 0, 4'h0, 0, 0, 0, "midrst_s1");
        sample(4'b0001, 8'h07, 1, 0, 4'h0, 0, 0, 0, "midrst_s2");
        apply_reset();
        checks += 2;
        if (bcd_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL midrst bcd_out got=%h exp=ffff", bcd_out);
        end
        if (digit_err !== 4'h0) begin
            errors++;
            $display("FAIL midrst digit_err got=%b exp=0000", digit_err);
        end
        sample(4'b0001, 8'h07, 1, 0, 4'h0, 0, 0, 0, "midrst_s3_nocommit");
    endtask

    task automatic test_dp();
`ifdef SEG7_DP_DECODE_EN
        sample(4'b0001, 8'hBF, 1, 0, 4'h0, 0, 0, 0, "dp_acq");
        sample(4'b0001, 8'hBF, 1, 0, 4'h0, 0, 0, 0, "dp_acq");
        sample(4'b0001, 8'hBF, 1, 1, 4'h0, 0, 1, 0, "dp_commit");
`else
        sample(4'b0001, 8'h3F, 1, 0, 4'h0, 0, 0, 0, "dp_ignored_s1");
        sample(4'b0001, 8'hBF, 1, 0, 4'h0, 0, 0, 0, "dp_ignored_s2");
        sample(4'b0001, 8'h3F, 1, 1, 4'h0, 0, 0, 0, "dp_ignored_commit");
        sample(4'b0001, 8'hBF, 1, 0, 4'h0, 0, 0, 0, "dp_ignored_locked");
`endif
    endtask

    initial begin
        rst       = 1'b1;
        sample_en = 1'b0;
        an_in     = 4'h0;
        seg_in    = 8'h00;
        exp_bcd   = 16'hFFFF;
        exp_err   = 4'h0;
        exp_dp    = 4'h0;
        test_reset();
        test_single_digit();
        test_scan();
        test_requalify();
        test_illegal_and_blank();
        test_reject_gate_reset();
        test_dp();
        @(negedge clk);
        sample_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d entries exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
